// File: rtl/coax_buffered_io.sv
// Buffered half-duplex host interface for one coax_tx/coax_rx pair: TX/RX FIFOs, line-direction
// arbitration and TX-to-RX turnaround. Optional loopback port under COAX_BUFFERED_IO_LOOPBACK_EN.
module coax_buffered_io #(
    parameter int unsigned WIDTH             = 10,
    parameter int unsigned TX_DEPTH          = 16,
    parameter int unsigned RX_DEPTH          = 16,
    parameter int unsigned TURNAROUND_CLOCKS = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
`ifdef COAX_BUFFERED_IO_LOOPBACK_EN
    input  logic                        loopback,
`endif
    input  logic                        tx_load,
    input  logic [WIDTH-1:0]            tx_data,
    output logic                        tx_full,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic                        tx_busy,
    input  logic                        rx_enable,
    output logic [WIDTH-1:0]            rx_data,
    output logic                        rx_data_available,
    input  logic                        rx_data_read,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        rx_overflow,
    output logic                        core_tx_load,
    output logic [WIDTH-1:0]            core_tx_data,
    input  logic                        core_tx_full,
    input  logic                        core_tx_active,
    output logic                        core_rx_enable,
    input  logic                        core_rx_active,
    input  logic [WIDTH-1:0]            core_rx_data,
    input  logic                        core_rx_data_available,
    output logic                        core_rx_data_read
);

    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam int unsigned TaW  = (TURNAROUND_CLOCKS > 0) ? $clog2(TURNAROUND_CLOCKS + 1) : 1;
    localparam logic [TxAw:0]  TxFullCnt = TX_DEPTH[TxAw:0];
    localparam logic [RxAw:0]  RxFullCnt = RX_DEPTH[RxAw:0];
    localparam logic [TaW-1:0] TaInit    = TURNAROUND_CLOCKS[TaW-1:0];

    typedef enum logic [1:0] {StIdle, StReceive, StTransmit, StTurnaround} state_e;

    state_e           state_q, state_d;
    logic [TaW-1:0]   ta_q, ta_d;
    logic             core_tx_load_q, load_prev_q, core_rx_en_q, core_rx_rd_q, rx_ovf_q;
    logic             core_rx_en_d, rx_ovf_d;
    logic [WIDTH-1:0] core_tx_data_q, core_tx_data_d;
    logic             tx_issue, lb_move, loop_en;

`ifdef COAX_BUFFERED_IO_LOOPBACK_EN
    assign loop_en = loopback;
`else
    assign loop_en = 1'b0;
`endif

    // TX FIFO
    logic [WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TxAw-1:0]  tx_wr_q, tx_rd_q;
    logic [TxAw:0]    tx_cnt_q;
    logic             tx_push, tx_pop, tx_empty;

    assign tx_full  = (tx_cnt_q == TxFullCnt);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_push  = tx_load && !tx_full;
    assign tx_pop   = tx_issue || lb_move;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= tx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
        end
    end

    // RX FIFO
    logic [WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RxAw-1:0]  rx_wr_q, rx_rd_q;
    logic [RxAw:0]    rx_cnt_q;
    logic             rx_push, rx_pop, rx_empty, rx_full, rx_accept, rx_req;
    logic [WIDTH-1:0] rx_wdata;

    assign rx_empty  = (rx_cnt_q == '0);
    assign rx_full   = (rx_cnt_q == RxFullCnt);
    assign rx_pop    = rx_data_read && !rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign rx_accept = !rx_full || rx_pop;
    assign lb_move   = loop_en && (state_q == StTransmit) && !tx_empty && rx_accept;
    // A core word waits (unacknowledged) while loopback owns the write port.
    assign rx_req    = core_rx_data_available && !core_rx_rd_q && !lb_move;
    assign rx_push   = lb_move || (rx_req && rx_accept);
    assign rx_wdata  = lb_move ? tx_mem[tx_rd_q] : core_rx_data;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_q] <= rx_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + 1'b1;
            else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
        end
    end

    always_comb begin
        rx_ovf_d = rx_ovf_q;
        if (!rx_enable)               rx_ovf_d = 1'b0;
        else if (rx_req && !rx_accept) rx_ovf_d = 1'b1;
    end

    // Direction arbitration
    always_comb begin
        state_d        = state_q;
        ta_d           = ta_q;
        tx_issue       = 1'b0;
        core_tx_data_d = core_tx_data_q;
        unique case (state_q)
            StIdle: begin
                if (!tx_empty)      state_d = StTransmit;
                else if (rx_enable) state_d = StReceive;
            end
            StReceive: begin
                if (!tx_empty && !core_rx_active)       state_d = StTransmit;
                else if (!rx_enable && !core_rx_active) state_d = StIdle;
            end
            StTransmit: begin
                if (!loop_en && !tx_empty && !core_tx_full && !core_tx_load_q) begin
                    tx_issue       = 1'b1;
                    core_tx_data_d = tx_mem[tx_rd_q];
                end else if (tx_empty && !core_tx_full && !core_tx_active &&
                             !core_tx_load_q && !load_prev_q) begin
                    if (TURNAROUND_CLOCKS == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StTurnaround;
                        ta_d    = TaInit;
                    end
                end
            end
            StTurnaround: begin
                if (ta_q == '0) state_d = StIdle;
                else            ta_d    = ta_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase
        core_rx_en_d = (state_d == StReceive) && rx_enable;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            ta_q           <= '0;
            core_tx_load_q <= 1'b0;
            load_prev_q    <= 1'b0;
            core_tx_data_q <= '0;
            core_rx_en_q   <= 1'b0;
            core_rx_rd_q   <= 1'b0;
            rx_ovf_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            ta_q           <= ta_d;
            core_tx_load_q <= tx_issue;
            load_prev_q    <= core_tx_load_q;
            core_tx_data_q <= core_tx_data_d;
            core_rx_en_q   <= core_rx_en_d;
            core_rx_rd_q   <= rx_req;
            rx_ovf_q       <= rx_ovf_d;
        end
    end

    assign tx_count          = tx_cnt_q;
    assign tx_busy           = (state_q == StTransmit) || (state_q == StTurnaround);
    assign rx_count          = rx_cnt_q;
    assign rx_data_available = !rx_empty;
    assign rx_data           = rx_empty ? '0 : rx_mem[rx_rd_q];
    assign rx_overflow       = rx_ovf_q;
    assign core_tx_load      = core_tx_load_q;
    assign core_tx_data      = core_tx_data_q;
    assign core_rx_enable    = core_rx_en_q;
    assign core_rx_data_read = core_rx_rd_q;

endmodule

// File: tb/tb_coax_buffered_io.sv
// Directed bench for coax_buffered_io with simple coax_tx/coax_rx models and queue scoreboards.
// Exercises the loopback path when COAX_BUFFERED_IO_LOOPBACK_EN is defined.
module tb_coax_buffered_io;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       loopback;
    logic       tx_load;
    logic [9:0] tx_data;
    logic       tx_full;
    logic [4:0] tx_count;
    logic       tx_busy;
    logic       rx_enable;
    logic [9:0] rx_data;
    logic       rx_data_available;
    logic       rx_data_read;
    logic [4:0] rx_count;
    logic       rx_overflow;
    logic       core_tx_load;
    logic [9:0] core_tx_data;
    logic       core_tx_full;
    logic       core_tx_active;
    logic       core_rx_enable;
    logic       core_rx_active;
    logic [9:0] core_rx_data;
    logic       core_rx_data_available;
    logic       core_rx_data_read;

    int checks = 0;
    int errors = 0;
    int load_pulses = 0;
    int rd_pulses = 0;
    logic [9:0] tx_q[$];
    logic [9:0] rx_exp[$];

    // coax_tx model: holding register full for 8 clocks after a load, line active for 10.
    int  full_cnt = 0;
    int  act_cnt = 0;
    logic force_full;
    assign core_tx_full   = (full_cnt != 0) || force_full;
    assign core_tx_active = (act_cnt != 0);

    always #5 clk = ~clk;

    coax_buffered_io #(
        .WIDTH(10),
        .TX_DEPTH(16),
        .RX_DEPTH(16),
        .TURNAROUND_CLOCKS(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef COAX_BUFFERED_IO_LOOPBACK_EN
        .loopback(loopback),
`endif
        .tx_load(tx_load),
        .tx_data(tx_data),
        .tx_full(tx_full),
        .tx_count(tx_count),
        .tx_busy(tx_busy),
        .rx_enable(rx_enable),
        .rx_data(rx_data),
        .rx_data_available(rx_data_available),
        .rx_data_read(rx_data_read),
        .rx_count(rx_count),
        .rx_overflow(rx_overflow),
        .core_tx_load(core_tx_load),
        .core_tx_data(core_tx_data),
        .core_tx_full(core_tx_full),
        .core_tx_active(core_tx_active),
        .core_rx_enable(core_rx_enable),
        .core_rx_active(core_rx_active),
        .core_rx_data(core_rx_data),
        .core_rx_data_available(core_rx_data_available),
        .core_rx_data_read(core_rx_data_read)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [9:0] w);
        tx_data = w;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
    endtask

    task automatic deliver(input logic [9:0] w, input bit with_read);
        core_rx_data           = w;
        core_rx_data_available = 1'b1;
        if (with_read) begin
            check("rx_head_before_pop", {22'd0, rx_data}, {22'd0, rx_exp.pop_front()});
            rx_data_read = 1'b1;
            rx_exp.push_back(w);
        end else if (rx_exp.size() < 16) begin
            rx_exp.push_back(w);
        end
        tick();
        rx_data_read = 1'b0;
        check("core_rx_ack", {31'd0, core_rx_data_read}, 32'd1);
        core_rx_data_available = 1'b0;
        tick();
    endtask

    // Models and output monitor run on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (core_tx_load) begin
            load_pulses++;
            full_cnt = 8;
            act_cnt  = 10;
            if (tx_q.size() == 0) check("tx_load_unexpected", {31'd0, core_tx_load}, 32'd0);
            else check("core_tx_data", {22'd0, core_tx_data}, {22'd0, tx_q.pop_front()});
        end else begin
            if (full_cnt > 0) full_cnt = full_cnt - 1;
            if (act_cnt > 0)  act_cnt  = act_cnt - 1;
        end
        if (core_rx_data_read) rd_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit gap_ok;
        reset_n = 1'b0;
        loopback = 1'b0;
        tx_load = 1'b0;
        tx_data = '0;
        rx_enable = 1'b0;
        rx_data_read = 1'b0;
        core_rx_active = 1'b0;
        core_rx_data = '0;
        core_rx_data_available = 1'b0;
        force_full = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst_tx_count", {27'd0, tx_count}, 32'd0);
        check("rst_rx_count", {27'd0, rx_count}, 32'd0);
        check("rst_flags", {26'd0, tx_full, tx_busy, rx_data_available, rx_overflow,
                            core_rx_enable, core_rx_data_read}, 32'd0);
        check("rst_rx_data", {22'd0, rx_data}, 32'd0);
        check("rst_core_tx", {21'd0, core_tx_load, core_tx_data}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Reset mid-TRANSMIT with 5 queued words
        force_full = 1'b1;
        for (int i = 0; i < 5; i++) push_tx(10'h050 + 10'(i));
        tick(); tick();
        check("pre_rst_count", {27'd0, tx_count}, 32'd5);
        check("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_count", {27'd0, tx_count}, 32'd0);
        check("mid_rst_outs", {28'd0, core_tx_load, tx_busy, core_rx_enable, tx_full}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // TX FIFO full boundary: 17th word dropped
        for (int i = 0; i < 16; i++) push_tx(10'h100 + 10'(i));
        check("tx_full_at_depth", {31'd0, tx_full}, 32'd1);
        check("tx_count_at_depth", {27'd0, tx_count}, 32'd16);
        push_tx(10'h1FF);
        check("tx_count_drop", {27'd0, tx_count}, 32'd16);
        #2 reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        force_full = 1'b0;
        tick();
        check("post_rst_count", {27'd0, tx_count}, 32'd0);
        check("no_loads_yet", load_pulses, 32'd0);

        // Three-word transmission then turnaround gap
        tx_q.push_back(10'h101); push_tx(10'h101);
        tx_q.push_back(10'h202); push_tx(10'h202);
        tx_q.push_back(10'h3FF); push_tx(10'h3FF);
        for (int i = 0; i < 200 && load_pulses < 3; i++) tick();
        check("three_loads", load_pulses, 32'd3);
        rx_enable = 1'b1;
        for (int i = 0; i < 50 && core_tx_active; i++) tick();
        check("tx_active_fell", {31'd0, core_tx_active}, 32'd0);
        gap_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (core_rx_enable !== 1'b0) gap_ok = 1'b0;
            tick();
        end
        check("turnaround_gap", {31'd0, gap_ok}, 32'd1);
        for (int i = 0; i < 8 && !core_rx_enable; i++) tick();
        check("rx_enabled_after_gap", {31'd0, core_rx_enable}, 32'd1);
        check("loads_total", load_pulses, 32'd3);

        // 20 words into a 16-deep RX FIFO, no host reads
        for (int i = 0; i < 20; i++) deliver(10'h010 + 10'(i), 1'b0);
        check("rx_count_full", {27'd0, rx_count}, 32'd16);
        check("rx_overflow_set", {31'd0, rx_overflow}, 32'd1);
        check("rx_ack_pulses", rd_pulses, 32'd20);
        check("rx_head_first", {22'd0, rx_data}, {22'd0, rx_exp[0]});
        rx_enable = 1'b0;
        tick(); tick();
        check("rx_overflow_clr", {31'd0, rx_overflow}, 32'd0);
        rx_enable = 1'b1;
        tick(); tick();

        // Full FIFO with simultaneous host read and core arrival
        deliver(10'h3AB, 1'b1);
        check("rx_count_swap", {27'd0, rx_count}, 32'd16);
        check("rx_no_overflow", {31'd0, rx_overflow}, 32'd0);
        rx_data_read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("rx_drain", {22'd0, rx_data}, {22'd0, rx_exp.pop_front()});
            tick();
        end
        rx_data_read = 1'b0;
        check("rx_drained", {21'd0, rx_data_available, rx_data}, 32'd0);
        rx_data_read = 1'b1;
        tick();
        rx_data_read = 1'b0;
        check("rx_read_empty", {27'd0, rx_count}, 32'd0);

        // TX request while a frame is being received
        core_rx_active = 1'b1;
        tx_q.push_back(10'h155); push_tx(10'h155);
        for (int i = 0; i < 10; i++) tick();
        check("tx_held_by_rx", load_pulses, 32'd3);
        check("tx_busy_held", {31'd0, tx_busy}, 32'd0);
        core_rx_active = 1'b0;
        for (int i = 0; i < 2 && !tx_busy; i++) tick();
        check("tx_after_rx", {31'd0, tx_busy}, 32'd1);
        for (int i = 0; i < 50 && load_pulses < 4; i++) tick();
        check("fourth_load", load_pulses, 32'd4);
        rx_enable = 1'b0;
        for (int i = 0; i < 100 && tx_busy; i++) tick();
        check("tx_done", {31'd0, tx_busy}, 32'd0);

`ifdef COAX_BUFFERED_IO_LOOPBACK_EN
        // Loopback: TX words land directly in the RX FIFO
        loopback = 1'b1;
        rx_exp.push_back(10'h0AA); push_tx(10'h0AA);
        rx_exp.push_back(10'h155); push_tx(10'h155);
        for (int i = 0; i < 50 && rx_count < 2; i++) tick();
        check("lb_rx_count", {27'd0, rx_count}, 32'd2);
        check("lb_first", {22'd0, rx_data}, {22'd0, rx_exp.pop_front()});
        rx_data_read = 1'b1;
        tick();
        rx_data_read = 1'b0;
        check("lb_second", {22'd0, rx_data}, {22'd0, rx_exp.pop_front()});
        rx_data_read = 1'b1;
        tick();
        rx_data_read = 1'b0;
        for (int i = 0; i < 100 && tx_busy; i++) tick();
        check("lb_no_core_load", load_pulses, 32'd4);
        check("lb_rx_en_low", {31'd0, core_rx_enable}, 32'd0);
        loopback = 1'b0;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
